// File: rtl/ahb_ram_ctrl.sv
// AHB-Lite slave front end for a 32-bit word-wide RAM with a 1-cycle registered read.
// Sequences word writes, reads, sub-word read-modify-writes and two-cycle ERROR responses.
module ahb_ram_ctrl #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        RAM_WRITE,
    output logic        RAM_READ,
    output logic [31:0] RAM_WR_ADDR,
    output logic [31:0] RAM_WR_DATA,
    output logic [31:0] RAM_RD_ADDR,
    input  logic [31:0] RAM_RD_DATA
);

    localparam int unsigned LA_W = ADDR_W + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_WORD, S_RD_WAIT, S_RD_DONE, S_RMW_RD, S_RMW_WR, S_ERR1, S_ERR2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [LA_W-1:0]   r_addr;
    logic [1:0]        r_size;
    logic [31:0]       r_wdata;
    logic [31:0]       r_hrdata;
    logic              r_hreadyout;
    logic              r_hresp;
    logic              r_ram_write;
    logic              r_ram_read;
    logic              w_open;
    logic              w_accept;
    logic              w_illegal;
    logic [31:0]       w_merge;
    logic              w_unused;

    // HTRANS[0] only separates IDLE/BUSY and NONSEQ/SEQ, which are handled alike.
    assign w_unused = HTRANS[0];

    assign w_open   = (r_state == S_IDLE) || (r_state == S_WR_WORD) || (r_state == S_RD_DONE)
                   || (r_state == S_RMW_WR) || (r_state == S_ERR2);
    assign w_accept = w_open & HSEL & HTRANS[1] & HREADY;

    always_comb begin
        w_illegal = 1'b0;
        if (HSIZE > 3'd2)
            w_illegal = 1'b1;
        if ((HADDR >> LA_W) != 32'd0)
            w_illegal = 1'b1;
        if ((HSIZE == 3'd1) && HADDR[0])
            w_illegal = 1'b1;
        if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
            w_illegal = 1'b1;
    end

    // Wait-state states advance unconditionally; ready states decode the new address phase.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_RD_WAIT: w_next = S_RD_DONE;
            S_RMW_RD:  w_next = S_RMW_WR;
            S_ERR1:    w_next = S_ERR2;
            default: begin
                if (w_accept) begin
                    if (w_illegal)
                        w_next = S_ERR1;
                    else if (!HWRITE)
                        w_next = S_RD_WAIT;
                    else if (HSIZE == 3'd2)
                        w_next = S_WR_WORD;
                    else
                        w_next = S_RMW_RD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_size      <= 2'd0;
            r_wdata     <= 32'd0;
            r_hrdata    <= 32'd0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_ram_write <= 1'b0;
            r_ram_read  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_hreadyout <= !(w_next inside {S_RD_WAIT, S_RMW_RD, S_ERR1});
            r_hresp     <= (w_next inside {S_ERR1, S_ERR2});
            r_ram_read  <= (w_next inside {S_RD_WAIT, S_RMW_RD});
            r_ram_write <= (w_next inside {S_WR_WORD, S_RMW_WR});
            if (w_accept) begin
                r_addr <= HADDR[LA_W-1:0];
                r_size <= HSIZE[1:0];
            end
            if (r_state == S_RMW_RD)
                r_wdata <= HWDATA;
            if (r_state == S_RD_DONE)
                r_hrdata <= RAM_RD_DATA;
        end
    end

    // Little-endian lane replacement over the word just read back from the RAM.
    always_comb begin
        w_merge = RAM_RD_DATA;
        if (r_size == 2'd0)
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[{r_addr[1:0], 3'b000} +: 8];
        else
            w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[{r_addr[1], 4'b0000} +: 16];
    end

    assign HREADYOUT   = r_hreadyout;
    assign HRESP       = r_hresp;
    assign RAM_WRITE   = r_ram_write;
    assign RAM_READ    = r_ram_read;
    assign HRDATA      = (r_state == S_RD_DONE) ? RAM_RD_DATA : r_hrdata;
    assign RAM_WR_ADDR = 32'(r_addr[LA_W-1:2]);
    assign RAM_RD_ADDR = 32'(r_addr[LA_W-1:2]);
    assign RAM_WR_DATA = (r_state == S_WR_WORD) ? HWDATA :
                         (r_state == S_RMW_WR)  ? w_merge : 32'd0;

endmodule
